// File: rtl/ps2_zx_keyboard.sv
// PS/2 set-2 keyboard receiver feeding a ZX Spectrum 8x5 key matrix read through port #FE.
// Define PS2_EXTKEYS_EN to map cursor keys and Backspace onto composite CS+digit virtual keys.
module ps2_zx_keyboard #(
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic [7:0] address_hi,
    output logic [4:0] keys,
    output logic [7:0] scancode,
    output logic       strobe,
    output logic       error
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    logic          clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
    logic          fall;
    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par;
    logic [CW-1:0] tcnt;

    logic [7:0][4:0] mat;
    logic [7:0][4:0] eff;
    logic            ext, rel;
    logic [2:0]      skip;
    logic [6:0]      lk;

    // Idle-high sync reset values so reset never fakes a falling edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_dat;
            dat_s2   <= dat_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            bit_cnt  <= 3'd0;
            shift    <= 8'h00;
            par      <= 1'b0;
            tcnt     <= '0;
            scancode <= 8'h00;
            strobe   <= 1'b0;
            error    <= 1'b0;
        end else begin
            strobe <= 1'b0;
            error  <= 1'b0;
            if (fall) begin
                tcnt <= '0;
                case (state)
                    S_IDLE: begin
                        if (!dat_s2) begin
                            state   <= S_DATA;
                            bit_cnt <= 3'd0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_PARITY;
                    end
                    S_PARITY: begin
                        par   <= dat_s2;
                        state <= S_STOP;
                    end
                    default: begin
                        if (dat_s2 && (^{shift, par})) begin
                            strobe   <= 1'b1;
                            scancode <= shift;
                        end else begin
                            error <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                endcase
            end else if (state != S_IDLE) begin
                // Abandon a stalled frame silently.
                if (tcnt == CW'(TIMEOUT - 1)) begin
                    state <= S_IDLE;
                    tcnt  <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end

    // Returns {valid, row, col} for a plain (non-E0) set-2 code.
    function automatic logic [6:0] lookup(input logic [7:0] code);
        case (code)
            8'h12: lookup = {1'b1, 3'd0, 3'd0};
            8'h1A: lookup = {1'b1, 3'd0, 3'd1};
            8'h22: lookup = {1'b1, 3'd0, 3'd2};
            8'h21: lookup = {1'b1, 3'd0, 3'd3};
            8'h2A: lookup = {1'b1, 3'd0, 3'd4};
            8'h1C: lookup = {1'b1, 3'd1, 3'd0};
            8'h1B: lookup = {1'b1, 3'd1, 3'd1};
            8'h23: lookup = {1'b1, 3'd1, 3'd2};
            8'h2B: lookup = {1'b1, 3'd1, 3'd3};
            8'h34: lookup = {1'b1, 3'd1, 3'd4};
            8'h15: lookup = {1'b1, 3'd2, 3'd0};
            8'h1D: lookup = {1'b1, 3'd2, 3'd1};
            8'h24: lookup = {1'b1, 3'd2, 3'd2};
            8'h2D: lookup = {1'b1, 3'd2, 3'd3};
            8'h2C: lookup = {1'b1, 3'd2, 3'd4};
            8'h16: lookup = {1'b1, 3'd3, 3'd0};
            8'h1E: lookup = {1'b1, 3'd3, 3'd1};
            8'h26: lookup = {1'b1, 3'd3, 3'd2};
            8'h25: lookup = {1'b1, 3'd3, 3'd3};
            8'h2E: lookup = {1'b1, 3'd3, 3'd4};
            8'h45: lookup = {1'b1, 3'd4, 3'd0};
            8'h46: lookup = {1'b1, 3'd4, 3'd1};
            8'h3E: lookup = {1'b1, 3'd4, 3'd2};
            8'h3D: lookup = {1'b1, 3'd4, 3'd3};
            8'h36: lookup = {1'b1, 3'd4, 3'd4};
            8'h4D: lookup = {1'b1, 3'd5, 3'd0};
            8'h44: lookup = {1'b1, 3'd5, 3'd1};
            8'h43: lookup = {1'b1, 3'd5, 3'd2};
            8'h3C: lookup = {1'b1, 3'd5, 3'd3};
            8'h35: lookup = {1'b1, 3'd5, 3'd4};
            8'h5A: lookup = {1'b1, 3'd6, 3'd0};
            8'h4B: lookup = {1'b1, 3'd6, 3'd1};
            8'h42: lookup = {1'b1, 3'd6, 3'd2};
            8'h3B: lookup = {1'b1, 3'd6, 3'd3};
            8'h33: lookup = {1'b1, 3'd6, 3'd4};
            8'h29: lookup = {1'b1, 3'd7, 3'd0};
            8'h59: lookup = {1'b1, 3'd7, 3'd1};
            8'h14: lookup = {1'b1, 3'd7, 3'd1};
            8'h3A: lookup = {1'b1, 3'd7, 3'd2};
            8'h31: lookup = {1'b1, 3'd7, 3'd3};
            8'h32: lookup = {1'b1, 3'd7, 3'd4};
            default: lookup = 7'd0;
        endcase
    endfunction

    // Extended (E0-prefixed) codes only reach the matrix via virtual keys.
    always_comb begin
        lk = ext ? 7'd0 : lookup(scancode);
    end

`ifdef PS2_EXTKEYS_EN
    logic [4:0] vk;
    logic [4:0] vk_sel;

    // vk: 0 Left, 1 Down, 2 Up, 3 Right, 4 Backspace
    always_comb begin
        vk_sel = 5'd0;
        if (ext) begin
            case (scancode)
                8'h6B: vk_sel = 5'b00001;
                8'h72: vk_sel = 5'b00010;
                8'h75: vk_sel = 5'b00100;
                8'h74: vk_sel = 5'b01000;
                default: vk_sel = 5'd0;
            endcase
        end else if (scancode == 8'h66) begin
            vk_sel = 5'b10000;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vk <= 5'd0;
        end else if (strobe && skip == 3'd0 && scancode != 8'hE0 && scancode != 8'hF0
                     && scancode != 8'hE1) begin
            vk <= rel ? (vk & ~vk_sel) : (vk | vk_sel);
        end
    end

    always_comb begin
        eff       = mat;
        eff[0][0] = mat[0][0] | (|vk);
        eff[3][4] = mat[3][4] | vk[0];
        eff[4][4] = mat[4][4] | vk[1];
        eff[4][3] = mat[4][3] | vk[2];
        eff[4][2] = mat[4][2] | vk[3];
        eff[4][0] = mat[4][0] | vk[4];
    end
`else
    always_comb begin
        eff = mat;
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mat  <= '0;
            ext  <= 1'b0;
            rel  <= 1'b0;
            skip <= 3'd0;
        end else if (strobe) begin
            if (skip != 3'd0) begin
                skip <= skip - 3'd1;
            end else if (scancode == 8'hE1) begin
                // Pause sends E1 plus seven further bytes with no break codes.
                skip <= 3'd7;
                ext  <= 1'b0;
                rel  <= 1'b0;
            end else if (scancode == 8'hE0) begin
                ext <= 1'b1;
            end else if (scancode == 8'hF0) begin
                rel <= 1'b1;
            end else begin
                if (lk[6]) mat[lk[5:3]][lk[2:0]] <= ~rel;
                ext <= 1'b0;
                rel <= 1'b0;
            end
        end
    end

    always_comb begin
        logic [4:0] acc;
        acc = 5'd0;
        for (int r = 0; r < 8; r++) begin
            if (!address_hi[r]) acc = acc | eff[r];
        end
        keys = ~acc;
    end

endmodule
